// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART RX bit timer.
// Frame-length and prescale-legality rules live here so every block agrees on them.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int DEFAULT_PRESCALE = 8;
    localparam int MIN_PRESCALE     = 4;

    // start + data + optional parity + one or two stop bits
    function automatic int frame_len(input int data_w, input logic par, input logic stop2);
        return 1 + data_w + (par ? 1 : 0) + (stop2 ? 2 : 1);
    endfunction

    function automatic logic prescale_legal(input int p, input int max);
        return (p[0] == 1'b0) && (p >= MIN_PRESCALE) && (p <= max);
    endfunction

endpackage

// File: rtl/rx_edge_prescaler.sv
// Oversampling edge counter for one RX bit, with mid-bit sample window and bit-end decode.
// The resync input restarts the count at edge 2 when a line transition lands outside the window.
module rx_edge_prescaler #(
    parameter int EDGE_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cnt_en,
    input  logic              active,
    input  logic              resync,
    input  logic [EDGE_W-1:0] p,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              sample_stb,
    output logic              sample_last,
    output logic              bit_end
);

    localparam logic [EDGE_W-1:0] ONE = EDGE_W'(1);
    localparam logic [EDGE_W-1:0] TWO = EDGE_W'(2);

    logic [EDGE_W-1:0] half;
    logic              in_win;
    logic              at_last;

    assign half    = {1'b0, p[EDGE_W-1:1]};
    assign in_win  = (edge_cnt == half - ONE) || (edge_cnt == half) || (edge_cnt == half + ONE);
    assign at_last = (edge_cnt == p);

    // The transition marks the boundary just crossed, so the next edge is edge 2 of the bit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt <= ONE;
        end else if (!cnt_en) begin
            edge_cnt <= ONE;
        end else if (resync && !in_win) begin
            edge_cnt <= TWO;
        end else if (at_last) begin
            edge_cnt <= ONE;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    assign sample_stb  = active && in_win;
    assign sample_last = active && (edge_cnt == half + ONE);
    assign bit_end     = active && at_last;

endmodule

// File: rtl/rx_bit_timer.sv
// UART RX bit/frame timer: config latch, IDLE/RUN/ERR control, bit counter and frame_done.
// Optional RX_EDGE_RESYNC_EN adds the rx_edge input that realigns the edge counter.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int MAX_PRESCALE = 32,
    localparam int EDGE_W      = $clog2(MAX_PRESCALE) + 1,
    localparam int BIT_W       = $clog2(DATA_W + 5)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
`ifdef RX_EDGE_RESYNC_EN
    input  logic              rx_edge,
`endif
    input  logic [EDGE_W-1:0] prescale,
    input  logic              par_en,
    input  logic              stop2,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sample_stb,
    output logic              sample_last,
    output logic              bit_end,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

    state_t            state;
    logic [EDGE_W-1:0] p_q;
    logic              par_q;
    logic              stop2_q;
    logic [BIT_W-1:0]  flen;
    logic              running;
    logic              cnt_en;
    logic              resync;

    assign flen    = BIT_W'(frame_len(DATA_W, par_q, stop2_q));
    assign running = (state == RUN);
    assign cnt_en  = running && enable;

`ifdef RX_EDGE_RESYNC_EN
    // The start bit is never realigned; its falling edge is what launched the frame.
    assign resync = rx_edge && (bit_cnt > BIT_ONE);
`else
    assign resync = 1'b0;
`endif

    rx_edge_prescaler #(
        .EDGE_W (EDGE_W)
    ) u_edge (
        .CLK         (CLK),
        .RST         (RST),
        .cnt_en      (cnt_en),
        .active      (running),
        .resync      (resync),
        .p           (p_q),
        .edge_cnt    (edge_cnt),
        .sample_stb  (sample_stb),
        .sample_last (sample_last),
        .bit_end     (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            p_q     <= EDGE_W'(DEFAULT_PRESCALE);
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        p_q     <= prescale;
                        par_q   <= par_en;
                        stop2_q <= stop2;
                        state   <= prescale_legal(int'(prescale), MAX_PRESCALE) ? RUN : ERR;
                    end
                end
                RUN: begin
                    if (!enable) state <= IDLE;
                end
                ERR: begin
                    if (!enable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bit advances on the last edge of a bit even if a resync fires on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            bit_cnt <= BIT_ONE;
        end else if (!cnt_en) begin
            bit_cnt <= BIT_ONE;
        end else if (bit_end) begin
            bit_cnt <= (bit_cnt < flen) ? bit_cnt + BIT_ONE : BIT_ONE;
        end
    end

    assign frame_done = bit_end && (bit_cnt == flen);
    assign cfg_err    = (state == ERR);

endmodule
